// File: rtl/axi_comp_pkg.sv
// rtl/axi_comp_pkg.sv - shared types and constants for the AXI write stager
package axi_comp_pkg;

  localparam int CMD_ADDR_W  = 32;
  localparam int CMD_COUNT_W = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    REQ,
    BUSY,
    FLUSH,
    DONE
  } stager_state_t;

  typedef struct packed {
    logic [CMD_ADDR_W-1:0]  addr;
    logic [CMD_COUNT_W-1:0] count;
  } cmd_t;

endpackage

// File: rtl/axi_wr_stager_fifo.sv
// rtl/axi_wr_stager_fifo.sv - fall-through synchronous FIFO with registered occupancy
module axi_wr_stager_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count == CW'(DEPTH));
  assign empty_o = (count == '0);
  assign count_o = count;
  // Refusals are decided from the registered count, so a pop never frees space for a same-cycle push.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = empty_o ? '0 : mem[rptr];

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wptr] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + AW'(1);
      end
      if (pop_ok) begin
        rptr <= rptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_wr_stager.sv
// rtl/axi_wr_stager.sv - buffers a full write burst before requesting the AXI manager and tracks its responses
// Optional per-command statistics counters enabled by AXI_WR_STAGER_STATS_EN.
module axi_wr_stager
  import axi_comp_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH   = CMD_ADDR_W,
  parameter int AXI_DATA_WIDTH   = 64,
  parameter int DATA_COUNT_WIDTH = CMD_COUNT_W,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        cmd_valid_i,
  output logic                        cmd_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_COUNT_WIDTH-1:0] cmd_count_i,
  input  logic                        s_valid_i,
  output logic                        s_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]   s_data_i,
  output logic                        wr_req_o,
  output logic [AXI_ADDR_WIDTH-1:0]   wr_addr_o,
  output logic [DATA_COUNT_WIDTH-1:0] wr_count_o,
  output logic [AXI_DATA_WIDTH-1:0]   wr_data_o,
  input  logic                        beat_pop_i,
  input  logic                        wr_rsp_i,
  input  logic [1:0]                  wr_err_i,
  output logic                        done_o,
  output logic [1:0]                  err_o,
  output logic [15:0]                 stat_cmds_o,
  output logic [15:0]                 stat_errs_o
);

  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CMP_W = (OCC_W > DATA_COUNT_WIDTH) ? OCC_W : DATA_COUNT_WIDTH;

  stager_state_t               state;
  cmd_t                        cmd_r;
  logic [DATA_COUNT_WIDTH-1:0] cnt_r;
  logic [DATA_COUNT_WIDTH-1:0] popped_r;
  logic [DATA_COUNT_WIDTH-1:0] popped_nxt;
  logic [DATA_COUNT_WIDTH-1:0] rsp_r;
  logic [DATA_COUNT_WIDTH-1:0] disc_r;
  logic [1:0]                  err_lat;
  logic                        cmd_ready_r;
  logic                        wr_req_r;
  logic                        done_r;
  logic [1:0]                  err_r;

  logic [OCC_W-1:0] occ;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             beat_take;
  logic             flush_pending;
  logic             flush_pop;
  logic             fill_ok;
  logic             cmd_bad;

  assign cnt_r = DATA_COUNT_WIDTH'(cmd_r.count);

  // The manager's beats are ignored while flushing; the flush drains the buffer by itself.
  assign beat_take     = beat_pop_i && !fifo_empty && (state != FLUSH);
  assign flush_pending = (state == FLUSH) && ((disc_r + popped_r) != cnt_r);
  assign flush_pop     = flush_pending && !fifo_empty;
  assign fifo_pop      = beat_take || flush_pop;
  assign fill_ok       = (CMP_W'(occ) >= CMP_W'(cnt_r));
  assign cmd_bad       = (cmd_count_i == '0) || (32'(cmd_count_i) > 32'(FIFO_DEPTH));

  always_comb begin
    popped_nxt = popped_r;
    if (state == BUSY && beat_take && popped_r != '1) begin
      popped_nxt = popped_r + DATA_COUNT_WIDTH'(1);
    end
  end

  axi_wr_stager_fifo #(
    .WIDTH (AXI_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .push_i      (s_valid_i),
    .push_data_i (s_data_i),
    .pop_i       (fifo_pop),
    .head_o      (wr_data_o),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (occ)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      cmd_r       <= '0;
      popped_r    <= '0;
      rsp_r       <= '0;
      disc_r      <= '0;
      err_lat     <= RESP_OKAY;
      cmd_ready_r <= 1'b0;
      wr_req_r    <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= RESP_OKAY;
    end else begin
      wr_req_r    <= 1'b0;
      done_r      <= 1'b0;
      cmd_ready_r <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready_r <= 1'b1;
          if (cmd_valid_i && cmd_ready_r) begin
            cmd_r       <= '{addr: CMD_ADDR_W'(cmd_addr_i), count: CMD_COUNT_W'(cmd_count_i)};
            popped_r    <= '0;
            rsp_r       <= '0;
            disc_r      <= '0;
            err_lat     <= RESP_OKAY;
            cmd_ready_r <= 1'b0;
            if (cmd_bad) begin
              state  <= DONE;
              done_r <= 1'b1;
              err_r  <= RESP_SLVERR;
            end else begin
              state <= FILL;
            end
          end
        end
        FILL: begin
          if (fill_ok) begin
            state    <= REQ;
            wr_req_r <= 1'b1;
          end
        end
        REQ: state <= BUSY;
        BUSY: begin
          popped_r <= popped_nxt;
          if (wr_rsp_i) begin
            if (wr_err_i != RESP_OKAY) begin
              err_lat <= wr_err_i;
              state   <= FLUSH;
            end else if (popped_nxt == cnt_r) begin
              state  <= DONE;
              done_r <= 1'b1;
              err_r  <= RESP_OKAY;
            end else if (rsp_r != '1) begin
              rsp_r <= rsp_r + DATA_COUNT_WIDTH'(1);
            end
          end
        end
        FLUSH: begin
          if (!flush_pending) begin
            state  <= DONE;
            done_r <= 1'b1;
            err_r  <= err_lat;
          end else begin
            disc_r <= disc_r + DATA_COUNT_WIDTH'(1);
          end
        end
        DONE: begin
          state       <= IDLE;
          cmd_ready_r <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o = cmd_ready_r;
  assign s_ready_o   = !fifo_full;
  assign wr_req_o    = wr_req_r;
  assign wr_addr_o   = AXI_ADDR_WIDTH'(cmd_r.addr);
  assign wr_count_o  = cnt_r;
  assign done_o      = done_r;
  assign err_o       = err_r;

`ifdef AXI_WR_STAGER_STATS_EN
  logic [15:0] stat_cmds_r;
  logic [15:0] stat_errs_r;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stat_cmds_r <= '0;
      stat_errs_r <= '0;
    end else if (done_r) begin
      if (stat_cmds_r != 16'hFFFF) begin
        stat_cmds_r <= stat_cmds_r + 16'd1;
      end
      if (err_r != RESP_OKAY && stat_errs_r != 16'hFFFF) begin
        stat_errs_r <= stat_errs_r + 16'd1;
      end
    end
  end

  assign stat_cmds_o = stat_cmds_r;
  assign stat_errs_o = stat_errs_r;
`else
  assign stat_cmds_o = '0;
  assign stat_errs_o = '0;
`endif

endmodule

// File: tb/tb_axi_wr_stager.sv
// tb/tb_axi_wr_stager.sv - directed scoreboard bench for axi_wr_stager
module tb_axi_wr_stager;
  import axi_comp_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int CW    = 8;
  localparam int DEPTH = 16;
`ifdef AXI_WR_STAGER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic [AW-1:0] cmd_addr_i = '0;
  logic [CW-1:0] cmd_count_i = '0;
  logic          s_valid_i = 1'b0;
  logic          s_ready_o;
  logic [DW-1:0] s_data_i = '0;
  logic          wr_req_o;
  logic [AW-1:0] wr_addr_o;
  logic [CW-1:0] wr_count_o;
  logic [DW-1:0] wr_data_o;
  logic          beat_pop_i = 1'b0;
  logic          wr_rsp_i = 1'b0;
  logic [1:0]    wr_err_i = 2'b00;
  logic          done_o;
  logic [1:0]    err_o;
  logic [15:0]   stat_cmds_o;
  logic [15:0]   stat_errs_o;

  axi_wr_stager #(
    .AXI_ADDR_WIDTH   (AW),
    .AXI_DATA_WIDTH   (DW),
    .DATA_COUNT_WIDTH (CW),
    .FIFO_DEPTH       (DEPTH)
  ) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_count_i (cmd_count_i),
    .s_valid_i   (s_valid_i),
    .s_ready_o   (s_ready_o),
    .s_data_i    (s_data_i),
    .wr_req_o    (wr_req_o),
    .wr_addr_o   (wr_addr_o),
    .wr_count_o  (wr_count_o),
    .wr_data_o   (wr_data_o),
    .beat_pop_i  (beat_pop_i),
    .wr_rsp_i    (wr_rsp_i),
    .wr_err_i    (wr_err_i),
    .done_o      (done_o),
    .err_o       (err_o),
    .stat_cmds_o (stat_cmds_o),
    .stat_errs_o (stat_errs_o)
  );

  always #5 clk_i = ~clk_i;

  int         checks = 0;
  int         failures = 0;
  int         wr_req_cnt = 0;
  int         done_cnt = 0;
  int         exp_req = 0;
  int         exp_done = 0;
  logic [1:0] last_err = 2'b00;
  logic [DW-1:0] data_q[$];
  logic [1:0]    err_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled on the falling edge; inputs change right after.
  task automatic tick();
    @(negedge clk_i);
    if (wr_req_o) wr_req_cnt++;
    if (done_o) begin
      done_cnt++;
      last_err = err_o;
    end
  endtask

  task automatic send_cmd(input logic [AW-1:0] addr, input logic [CW-1:0] cnt);
    bit ok;
    ok = 1'b0;
    cmd_valid_i = 1'b1;
    cmd_addr_i  = addr;
    cmd_count_i = cnt;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready_o) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    cmd_valid_i = 1'b0;
    check("cmd_accept", 64'(ok), 64'd1);
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    s_valid_i = 1'b1;
    s_data_i  = d;
    data_q.push_back(d);
    tick();
    s_valid_i = 1'b0;
  endtask

  task automatic pop_beat(input string tag);
    logic [DW-1:0] e;
    e = (data_q.size() > 0) ? data_q.pop_front() : '0;
    check(tag, 64'(wr_data_o), 64'(e));
    beat_pop_i = 1'b1;
    tick();
    beat_pop_i = 1'b0;
  endtask

  task automatic send_rsp(input logic [1:0] e);
    wr_rsp_i = 1'b1;
    wr_err_i = e;
    tick();
    wr_rsp_i = 1'b0;
    wr_err_i = 2'b00;
  endtask

  task automatic wait_req(input string tag);
    exp_req++;
    for (int i = 0; i < 20 && wr_req_cnt < exp_req; i++) tick();
    check({tag, "_req"}, 64'(wr_req_cnt), 64'(exp_req));
    tick();
    check({tag, "_req_1cyc"}, 64'(wr_req_o), 64'd0);
  endtask

  task automatic wait_done(input string tag);
    logic [1:0] e;
    e = (err_q.size() > 0) ? err_q.pop_front() : 2'b11;
    for (int i = 0; i < 30 && done_cnt < exp_done; i++) tick();
    check({tag, "_done"}, 64'(done_cnt), 64'(exp_done));
    check({tag, "_err"}, 64'(last_err), 64'(e));
    tick();
    check({tag, "_done_1cyc"}, 64'(done_o), 64'd0);
    check({tag, "_err_held"}, 64'(err_o), 64'(e));
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom(), $urandom()} | 64'h1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_s_ready", 64'(s_ready_o), 64'd1);
    check("rst_cmd_ready", 64'(cmd_ready_o), 64'd0);
    check("rst_wr_req", 64'(wr_req_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_wr_data", 64'(wr_data_o), 64'd0);
    check("rst_wr_addr", 64'(wr_addr_o), 64'd0);
    check("rst_stat_cmds", 64'(stat_cmds_o), 64'd0);
    rstn_i = 1'b1;
    tick();
    tick();
    check("idle_cmd_ready", 64'(cmd_ready_o), 64'd1);

    // 1: four-beat clean burst
    send_cmd(32'h1000, 8'd4);
    for (int i = 0; i < 4; i++) begin
      push_word(rnd_word());
      check("s1_no_early_req", 64'(wr_req_cnt), 64'(exp_req));
    end
    wait_req("s1");
    check("s1_addr", 64'(wr_addr_o), 64'h1000);
    check("s1_count", 64'(wr_count_o), 64'd4);
    for (int i = 0; i < 4; i++) pop_beat("s1_data");
    err_q.push_back(RESP_OKAY);
    exp_done++;
    send_rsp(RESP_OKAY);
    wait_done("s1");

    // 2: one clean response per beat, done only after the last
    send_cmd(32'h2000, 8'd3);
    for (int i = 0; i < 3; i++) push_word(rnd_word());
    wait_req("s2");
    err_q.push_back(RESP_OKAY);
    for (int i = 0; i < 3; i++) begin
      pop_beat("s2_data");
      if (i == 2) exp_done++;
      send_rsp(RESP_OKAY);
      if (i < 2) begin
        tick();
        tick();
        check("s2_no_early_done", 64'(done_cnt), 64'(exp_done));
      end
    end
    wait_done("s2");

    // 3: error after two beats flushes the rest
    send_cmd(32'h3000, 8'd4);
    for (int i = 0; i < 4; i++) push_word(rnd_word());
    wait_req("s3");
    pop_beat("s3_data");
    pop_beat("s3_data");
    err_q.push_back(RESP_SLVERR);
    exp_done++;
    send_rsp(RESP_SLVERR);
    void'(data_q.pop_front());
    void'(data_q.pop_front());
    wait_done("s3");
    check("s3_fifo_empty", 64'(wr_data_o), 64'd0);
    check("s3_s_ready", 64'(s_ready_o), 64'd1);
    check("s3_stat_cmds", 64'(stat_cmds_o), STATS ? 64'd3 : 64'd0);
    check("s3_stat_errs", 64'(stat_errs_o), STATS ? 64'd1 : 64'd0);

    // 4: illegal counts are rejected without a request
    send_cmd(32'h4000, 8'd0);
    err_q.push_back(RESP_SLVERR);
    exp_done++;
    wait_done("s4_zero");
    send_cmd(32'h5000, 8'd17);
    err_q.push_back(RESP_SLVERR);
    exp_done++;
    wait_done("s4_over");
    tick();
    check("s4_no_req", 64'(wr_req_cnt), 64'(exp_req));
    check("s4_stat_errs", 64'(stat_errs_o), STATS ? 64'd3 : 64'd0);

    // 5: full FIFO, pop with refused push, pop while empty
    for (int i = 0; i < DEPTH; i++) push_word(rnd_word());
    check("s5_full", 64'(s_ready_o), 64'd0);
    check("s5_head", 64'(wr_data_o), 64'(data_q[0]));
    void'(data_q.pop_front());
    s_valid_i  = 1'b1;
    s_data_i   = 64'hDEAD_BEEF_0000_0001;
    beat_pop_i = 1'b1;
    tick();
    s_valid_i  = 1'b0;
    beat_pop_i = 1'b0;
    check("s5_occ15_ready", 64'(s_ready_o), 64'd1);
    for (int i = 0; i < DEPTH - 1; i++) pop_beat("s5_data");
    check("s5_empty", 64'(wr_data_o), 64'd0);
    beat_pop_i = 1'b1;
    tick();
    beat_pop_i = 1'b0;
    check("s5_empty_pop", 64'(wr_data_o), 64'd0);
    push_word(64'h5555_AAAA_1234_5678);
    pop_beat("s5_after_empty_pop");
    check("s5_empty_again", 64'(wr_data_o), 64'd0);

    // 6: reset during BUSY abandons the command
    send_cmd(32'h6000, 8'd2);
    push_word(rnd_word());
    push_word(rnd_word());
    wait_req("s6");
    rstn_i = 1'b0;
    #1;
    check("s6_rst_data", 64'(wr_data_o), 64'd0);
    check("s6_rst_done", 64'(done_o), 64'd0);
    check("s6_rst_ready", 64'(s_ready_o), 64'd1);
    tick();
    tick();
    rstn_i = 1'b1;
    data_q.delete();
    tick();
    tick();
    check("s6_idle", 64'(cmd_ready_o), 64'd1);
    check("s6_no_done", 64'(done_cnt), 64'(exp_done));
    check("s6_empty", 64'(wr_data_o), 64'd0);
    check("s6_stat_cmds", 64'(stat_cmds_o), 64'd0);
    check("s6_stat_errs", 64'(stat_errs_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_wr_stager.md
Name: axi_wr_stager

Overview:
- Write-side front end that sits directly upstream of the AXI4 manager's write channel.
- Accepts a write command (start address, beat count) and a stream of data words, and buffers the words in an internal FIFO.
- Issues the manager's write request only once every beat of the command is resident. The manager samples its data input without stalling, so the FIFO must never underflow.
- Pops one word per beat the manager consumes, tracks B responses, and reports completion or error per command.

Parameters:
AXI_ADDR_WIDTH, 32, address width
AXI_DATA_WIDTH, 64, data word width
DATA_COUNT_WIDTH, 8, width of the beat-count field
FIFO_DEPTH, 16, buffer depth in words; power of 2, at least 2

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid and ready are both high
cmd_addr_i  in  AXI_ADDR_WIDTH  start byte address
cmd_count_i  in  DATA_COUNT_WIDTH  beats in the command
s_valid_i  in  1  data word valid
s_ready_o  out  1  data word accepted when valid and ready are both high
s_data_i  in  AXI_DATA_WIDTH  data word
wr_req_o  out  1  write request to the manager
wr_addr_o  out  AXI_ADDR_WIDTH  latched command address
wr_count_o  out  DATA_COUNT_WIDTH  latched command count
wr_data_o  out  AXI_DATA_WIDTH  FIFO head word
beat_pop_i  in  1  manager consumed one W beat
wr_rsp_i  in  1  manager B handshake pulse
wr_err_i  in  2  BRESP accompanying wr_rsp_i
done_o  out  1  one-cycle completion pulse
err_o  out  2  status of the completed command; held until the next done_o
stat_cmds_o  out  16  count of completed commands (optional feature)
stat_errs_o  out  16  count of errored commands (optional feature)

Behaviour:
- Reset is asynchronous, active-low, on rstn_i; clock is clk_i.
- Reset clears the FIFO, returns the FSM to IDLE, and drives every output to 0. The one exception is s_ready_o, which is 1 because the FIFO is empty and not full.
- Reset asserted mid-command abandons the command silently: no done_o pulse.

FIFO:
- Synchronous, fall-through. wr_data_o equals the head word, or 0 when empty.
- s_ready_o = not full, derived from a registered occupancy count.
- Push and pop in the same cycle are legal at any occupancy. When full and popping, a push in the same cycle is still refused because s_ready_o is low.
- beat_pop_i while empty is ignored; occupancy saturates at 0.
- The FIFO accepts data in every state, including before a command arrives.

State machine, with registers cnt_r (beats outstanding), popped_r and rsp_r:
- IDLE: cmd_ready_o = 1. On a command handshake, latch address and count, then:
  - cmd_count_i == 0 or cmd_count_i > FIFO_DEPTH: command is rejected. Next cycle is DONE with err = 2'b10; wr_req_o is never raised.
  - otherwise go to FILL.
- FILL: wait until occupancy ≥ cnt_r, then go to REQ.
- REQ: wr_req_o = 1 for exactly one cycle, then go to BUSY.
- BUSY: each beat_pop_i increments popped_r.
  - On wr_rsp_i with wr_err_i != 0: latch the error and go to FLUSH.
  - On wr_rsp_i with wr_err_i == 0 and popped_r (including any pop in the same cycle) == cnt_r: go to DONE with err = 2'b00.
  - Other clean responses are intermediate single-beat responses: ignore them, except that rsp_r increments.
- FLUSH: discard FIFO words internally, one per cycle, until discarded plus popped equals cnt_r; then go to DONE. beat_pop_i is ignored in FLUSH.
- DONE: done_o = 1 and err_o is updated, for one cycle; then go to IDLE.

Width rules:
- Counters are DATA_COUNT_WIDTH bits wide and never wrap.
- Occupancy is $clog2(FIFO_DEPTH)+1 bits wide.

Optional Feature:
- Macro AXI_WR_STAGER_STATS_EN.
- Defined: stat_cmds_o increments on each done_o pulse. stat_errs_o increments on each done_o pulse with err_o != 0. Both saturate at 16'hFFFF and are cleared by reset.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Package axi_comp_pkg holds:
  - the stager state enum (IDLE, FILL, REQ, BUSY, FLUSH, DONE);
  - AXI response localparams RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;
  - a command struct {addr, count}.
- Sub-module axi_wr_stager_fifo: a parameterised fall-through synchronous FIFO with push, pop, full, empty and count.

Test Plan:
1. Command {0x1000, 4} with 4 words pushed: wr_req_o pulses once after the 4th push. Four beat_pop_i pulses return the words in order, then one clean wr_rsp_i gives done_o with err_o = 00.
2. Command count 3 with three clean wr_rsp_i pulses, one after each pop: done_o only after the third response; no early done_o.
3. Command count 4, error after 2 pops (wr_err_i = 10): FLUSH discards 2 words, then done_o with err_o = 10, and the FIFO is empty afterwards.
4. Command count 0 and command count 17 (FIFO_DEPTH 16): each produces done_o with err_o = 10 and never raises wr_req_o.
5. Fill to 16 words: s_ready_o = 0. beat_pop_i and s_valid_i asserted in the same cycle: pop only, occupancy 15. beat_pop_i while empty: no change.
6. rstn_i asserted during BUSY: FIFO is empty, state is IDLE, no done_o pulse. With AXI_WR_STAGER_STATS_EN defined, stat_cmds_o and stat_errs_o are 0 after reset, and stat_errs_o = 1 after scenario 3.
